// File: rtl/writeback_stage5.sv
// MEM/WB pipeline register and write-back: sub-word load extract/extend, r0 write suppression, misaligned-load flag, retire counter.
// Latency: 1 cycle from MEM inputs to the register-file write port outputs.
// Backpressure: stall holds every output register; flush (higher priority) loads a bubble.
module writeback_stage5 #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_valid,
  input  logic               mem_reg_write,
  input  logic               mem_to_reg,
  input  logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic [DATA_W-1:0]  mem_alu_result,
  input  logic [DATA_W-1:0]  mem_load_data,
  input  logic [1:0]         mem_load_size,
  input  logic               mem_load_unsigned,
  input  logic               stall,
  input  logic               flush,
  output logic [ADDR_W-1:0]  wd_addr,
  output logic [DATA_W-1:0]  wd_data,
  output logic               w_enable,
  output logic               wb_valid,
  output logic               wb_misalign,
  output logic [COUNT_W-1:0] retired_count
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  logic [1:0]        off;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] wr_data;
  logic              misalign;
  logic              wr_en;

  assign off = mem_alu_result[1:0];

  // Select the addressed lane, extend it, and decide whether the write may go ahead.
  always_comb begin
    load_byte = 8'h00;
    load_half = 16'h0000;
    load_ext  = '0;
    wr_data   = '0;
    misalign  = 1'b0;
    wr_en     = 1'b0;

    // Little-endian byte lanes.
    case (off)
      2'd0:    load_byte = mem_load_data[7:0];
      2'd1:    load_byte = mem_load_data[15:8];
      2'd2:    load_byte = mem_load_data[23:16];
      default: load_byte = mem_load_data[31:24];
    endcase

    // Half lane picked by off[1]; off[0]=1 is reported as misaligned below.
    load_half = off[1] ? mem_load_data[31:16] : mem_load_data[15:0];

    case (mem_load_size)
      SZ_BYTE: load_ext = {{(DATA_W-8){~mem_load_unsigned & load_byte[7]}}, load_byte};
      SZ_HALF: load_ext = {{(DATA_W-16){~mem_load_unsigned & load_half[15]}}, load_half};
      default: load_ext = mem_load_data;
    endcase

    // Size 11 is handled as a word access for alignment as well as data.
    misalign = mem_valid & mem_reg_write & mem_to_reg &
               (((mem_load_size == SZ_HALF) & off[0]) |
                (mem_load_size[1] & (off != 2'b00)));

    wr_data = mem_to_reg ? load_ext : mem_alu_result;
    wr_en   = mem_valid & mem_reg_write & (mem_rd_addr != '0) & ~misalign;
  end

  // WB register: flush beats stall beats capture; counter counts every live capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_addr       <= '0;
      wd_data       <= '0;
      w_enable      <= 1'b0;
      wb_valid      <= 1'b0;
      wb_misalign   <= 1'b0;
      retired_count <= '0;
    end else if (flush) begin
      wd_addr     <= '0;
      wd_data     <= '0;
      w_enable    <= 1'b0;
      wb_valid    <= 1'b0;
      wb_misalign <= 1'b0;
    end else if (!stall) begin
      wd_addr     <= mem_rd_addr;
      wd_data     <= wr_data;
      w_enable    <= wr_en;
      wb_valid    <= mem_valid;
      wb_misalign <= misalign;
      if (mem_valid) begin
        retired_count <= retired_count + {{(COUNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
